pipe_stage_elastic: RTL

Parametrised, elastic pipeline-stage register for the RISC-V core: carries one WIDTH-bit payload bundle between adjacent stages (e.g. Decode to Execute) with valid/ready flow control, a two-entry skid buffer for full throughput under backpressure, and a synchronous flush for hazard squashing. It replaces the fixed per-stage register banks with one reusable block, adding stall support and optional per-stage performance counters.

---
 rtl/pipe_stage_elastic_if.sv | 18 +
 rtl/pipe_stage_elastic.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if
//   Valid/ready payload stream between adjacent pipeline stages.
//   master : producer side (drives valid, data; samples ready)
//   slave  : consumer side (samples valid, data; drives ready)
//   Signals:
//     valid  payload on data is valid this cycle
//     ready  consumer accepts this cycle
//     data   WIDTH-bit payload bundle
interface pipe_stage_elastic_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline-stage register with a two-entry skid buffer and a
//   synchronous flush. One payload per cycle under continuous out ready;
//   the skid register absorbs the item in flight when downstream stalls,
//   so in_ready/out_valid are decoded from flops only.
//
//   Optional macro: PIPE_STAGE_PERF_EN
//     defined   -> stall_cnt / bubble_cnt saturating performance counters
//     undefined -> counter ports tied to zero
//
//   Ports:
//     clk         rising-edge clock
//     reset_n     asynchronous active-low reset
//     flush       synchronous squash of all held entries
//     in_if       slave stream  (in_valid / in_ready / in_data)
//     out_if      master stream (out_valid / out_ready / out_data)
//     stall_cnt   cycles with out_valid=1 and out_ready=0
//     bubble_cnt  cycles with out_ready=1 and out_valid=0
module pipe_stage_elastic #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    pipe_stage_elastic_if.slave   in_if,
    pipe_stage_elastic_if.master  out_if,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        FULL  = 2'd1,   // main register valid
        SKID  = 2'd2    // main and skid registers valid
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_w;

    assign out_valid_w  = (state_q != EMPTY);
    assign out_if.valid = out_valid_w;
    assign out_if.data  = main_q;
    assign in_if.ready  = (state_q != SKID);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash wins over any transfer offered in the same cycle.
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_if.valid) begin
                        main_d  = in_if.data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_if.valid && out_if.ready) begin
                        main_d = in_if.data;
                    end else if (in_if.valid) begin
                        // Downstream stalled: park the in-flight item.
                        skid_d  = in_if.data;
                        state_d = SKID;
                    end else if (out_if.ready) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_if.ready) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Saturating counters; flush leaves them untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_w && !out_if.ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!out_valid_w && out_if.ready && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
